// File: rtl/freq_meter_serial_pkg.sv
// Shared types and defaults for the serial frequency meter.
package freq_meter_serial_pkg;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        COUNT     = 1'b1
    } state_t;
endpackage

// File: rtl/freq_meter_serial_if.sv
// Measurement bus: enable/serial stream in, period/high_time/valid/timeout out.
interface freq_meter_serial_if #(
    parameter int CNT_W = freq_meter_serial_pkg::CNT_W_DEF
);
    logic             enable;
    logic             serial_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;

    modport master (
        output enable, serial_in,
        input  period, high_time, valid, timeout
    );

    modport slave (
        input  enable, serial_in,
        output period, high_time, valid, timeout
    );
endinterface

// File: rtl/freq_meter_serial_edge_detect_rise.sv
// Rising-edge detector: registers the input and flags a 0->1 transition.
module edge_detect_rise (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= din;
    end

    assign rise = din & ~prev_q;
endmodule

// File: rtl/freq_meter_serial.sv
// Measures period and (with FREQ_METER_DUTY_EN defined) high time of a serial
// stream between consecutive rising edges; times out after 2^CNT_W-1 cycles.
module freq_meter_serial
    import freq_meter_serial_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic                clock,
    input logic                reset,
    freq_meter_serial_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rise;

    edge_detect_rise u_edge (
        .clock (clock),
        .reset (reset),
        .din   (bus.serial_in),
        .rise  (rise)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= WAIT_EDGE;
            cnt         <= '0;
            bus.period  <= '0;
            bus.valid   <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            if (!bus.enable) begin
                state <= WAIT_EDGE;
                cnt   <= '0;
            end else begin
                case (state)
                    WAIT_EDGE: begin
                        if (rise) begin
                            cnt   <= CNT_W'(1);
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        // An edge on the saturating cycle wins over the timeout.
                        if (rise) begin
                            bus.period  <= cnt;
                            bus.valid   <= 1'b1;
                            bus.timeout <= 1'b0;
                            cnt         <= CNT_W'(1);
                        end else if (cnt == CNT_MAX) begin
                            bus.timeout <= 1'b1;
                            state       <= WAIT_EDGE;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= WAIT_EDGE;
                endcase
            end
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt;

    // Mirrors the cnt sequencing so hcnt can never run ahead of cnt.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt          <= '0;
            bus.high_time <= '0;
        end else if (!bus.enable) begin
            hcnt <= '0;
        end else if (state == WAIT_EDGE) begin
            if (rise) hcnt <= CNT_W'(1);
        end else if (rise) begin
            bus.high_time <= hcnt;
            hcnt          <= CNT_W'(1);
        end else if (cnt == CNT_MAX) begin
            hcnt <= '0;
        end else if (bus.serial_in) begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end
`else
    assign bus.high_time = '0;
`endif
endmodule

// File: tb/tb_freq_meter_serial.sv
// Scoreboard bench: stimulus pushes expected captures, monitors pop on valid.
module tb_freq_meter_serial;
    typedef struct {
        int period;
        int high;
    } exp_t;

`ifdef FREQ_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser = 1'b0;
    logic en8 = 1'b0;
    logic en4 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;

    always #5 clk = ~clk;

    freq_meter_serial_if #(.CNT_W(8)) bus8 ();
    freq_meter_serial_if #(.CNT_W(4)) bus4 ();

    assign bus8.serial_in = ser;
    assign bus4.serial_in = ser;
    assign bus8.enable    = en8;
    assign bus4.enable    = en4;

    freq_meter_serial #(.CNT_W(8)) u_dut8 (.clock(clk), .reset(rst), .bus(bus8));
    freq_meter_serial #(.CNT_W(4)) u_dut4 (.clock(clk), .reset(rst), .bus(bus4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int p, input int h);
        exp_t e;
        e.period = p;
        e.high   = DUTY ? h : 0;
        return e;
    endfunction

    task automatic bit_out(input logic b);
        ser = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pat(input logic [15:0] pat, input int nbits);
        for (int i = 0; i < nbits; i++) bit_out(pat[15 - (i % 16)]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ser = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst period8",  32'(bus8.period),    0);
        check("rst high8",    32'(bus8.high_time), 0);
        check("rst valid8",   32'(bus8.valid),     0);
        check("rst timeout8", 32'(bus8.timeout),   0);
        check("rst timeout4", 32'(bus4.timeout),   0);
        rst = 1'b0;
    endtask

    // Monitors: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus8.valid === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 unexpected valid: got valid=1 period=%0d expected no valid", bus8.period);
            end else begin
                e8 = q8.pop_front();
                check("dut8 period",  32'(bus8.period),    32'(e8.period));
                check("dut8 high",    32'(bus8.high_time), 32'(e8.high));
                check("dut8 timeout", 32'(bus8.timeout),   0);
            end
        end
    end

    always @(negedge clk) begin
        if (bus4.valid === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected valid: got valid=1 period=%0d expected no valid", bus4.period);
            end else begin
                e4 = q4.pop_front();
                check("dut4 period",  32'(bus4.period),    32'(e4.period));
                check("dut4 high",    32'(bus4.high_time), 32'(e4.high));
                check("dut4 timeout", 32'(bus4.timeout),   0);
            end
        end
    end

    initial begin
        // 1100 pattern: edges every 4 bits, first edge only arms
        en8 = 1'b1; en4 = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) q8.push_back(mk(4, 2));
        run_pat(16'b1100110011001100, 32);

        // single-one pattern: period 16, one high cycle
        do_reset();
        for (int i = 0; i < 2; i++) q8.push_back(mk(16, 1));
        run_pat(16'b1000000000000000, 48);

        // enable dropped for 3 cycles mid-period, edge at bit 12 ignored
        do_reset();
        for (int i = 0; i < 4; i++) q8.push_back(mk(4, 2));
        for (int i = 0; i < 28; i++) begin
            if (i == 10) en8 = 1'b0;
            if (i == 13) en8 = 1'b1;
            bit_out(i % 4 < 2);
        end

        // reset coincident with a capturing edge
        do_reset();
        q8.push_back(mk(4, 2));
        run_pat(16'b1100110011001100, 8);
        ser = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstedge period8",  32'(bus8.period),    0);
        check("rstedge high8",    32'(bus8.high_time), 0);
        check("rstedge valid8",   32'(bus8.valid),     0);
        check("rstedge timeout8", 32'(bus8.timeout),   0);
        ser = 1'b0;
        repeat (3) bit_out(1'b0);

        // timeout on 4-bit counter, sticky through arming edge
        en8 = 1'b0; en4 = 1'b1;
        do_reset();
        bit_out(1'b1);
        repeat (13) bit_out(1'b0);
        check("no early timeout4", 32'(bus4.timeout), 0);
        repeat (7) bit_out(1'b0);
        check("timeout4 set", 32'(bus4.timeout), 1);
        q4.push_back(mk(5, 1));
        bit_out(1'b1);
        check("timeout4 sticky", 32'(bus4.timeout), 1);
        repeat (4) bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        check("timeout4 cleared", 32'(bus4.timeout), 0);

        // edge exactly on the saturating cycle is captured
        do_reset();
        q4.push_back(mk(15, 1));
        bit_out(1'b1);
        repeat (14) bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        check("sat edge no timeout4", 32'(bus4.timeout), 0);
        repeat (3) bit_out(1'b0);

        check("q8 drained", 32'(q8.size()), 0);
        check("q4 drained", 32'(q4.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
